sync_ptr_gray_nstage: RTL and testbench

Parametrised successor to the two-flop gray-pointer synchronizer used in the async FIFO pointer path. It brings a gray-coded pointer from a foreign clock domain into the wclk domain through a configurable number of flop stages. It then converts the pointer to binary and reports, per cycle, whether and by how much the pointer advanced. It also flags illegal pointer movement (backward, or more than one FIFO depth), which indicates metastability escape or a broken source. It sits on the write side (rptr into wclk) or, mirrored, on the read side of any FIFO in the basal FIFO library.

---
 rtl/fifo_sync_pkg.sv | 25 ++
 rtl/sync_ptr_gray_nstage_sync_chain.sv | 30 +++
 rtl/sync_ptr_gray_nstage.sv | 100 ++++++++++
 tb/tb_sync_ptr_gray_nstage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// Shared helpers for FIFO pointer synchronizers: gray/binary conversion and sync-depth limits.
// Functions work on a max-width container; callers zero-extend narrower pointers.
package fifo_sync_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;
    localparam int unsigned PTR_W_MAX       = 32;

    typedef logic [PTR_W_MAX-1:0] ptr_t;

    // b[i] is the XOR of g[msb..i]; zero upper bits make this width-agnostic.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = '0;
        for (int i = 0; i < PTR_W_MAX; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sync_ptr_gray_nstage_sync_chain.sv
// Bare multi-flop synchronizer chain with synchronous active-high reset.
// Kept in its own module so CDC constraints can target it exclusively.
module sync_chain #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] s_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
            end
        end else begin
            s_q[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                s_q[k] <= s_q[k-1];
            end
        end
    end

    assign q = s_q[STAGES-1];

endmodule

// File: rtl/sync_ptr_gray_nstage.sv
// Gray pointer synchronizer into wclk with binary conversion, per-cycle advance
// reporting and an optional sticky illegal-movement checker.
module sync_ptr_gray_nstage
    import fifo_sync_pkg::*;
#(
    parameter int unsigned ADDRSIZE    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          CHK_EN      = 1'b1
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic [ADDRSIZE:0] rptr,
    output logic [ADDRSIZE:0] wq_rptr,
    output logic [ADDRSIZE:0] wq_rbin,
    output logic              wq_rptr_upd,
    output logic [ADDRSIZE:0] wq_rptr_delta,
    output logic              gray_err,
    input  logic              gray_err_clr
);

    localparam int unsigned PTR_W = ADDRSIZE + 1;
    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(1) << ADDRSIZE;

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("sync_ptr_gray_nstage: SYNC_STAGES must be in 2..4");
    end

    if (PTR_W > PTR_W_MAX) begin : g_bad_width
        $error("sync_ptr_gray_nstage: ADDRSIZE too large for fifo_sync_pkg helpers");
    end

    logic [PTR_W-1:0] sync_bin;
    logic [PTR_W-1:0] delta_d;
    logic [PTR_W-1:0] rbin_q;
    logic [PTR_W-1:0] delta_q;
    logic             upd_q;

    sync_chain #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk (wclk),
        .rst (wrst),
        .d   (rptr),
        .q   (wq_rptr)
    );

    assign sync_bin = PTR_W'(gray2bin(ptr_t'(wq_rptr)));
    // Unsigned modular difference: wrap 2^PTR_W-1 -> 0 yields 1.
    assign delta_d  = sync_bin - rbin_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            rbin_q  <= '0;
            upd_q   <= 1'b0;
            delta_q <= '0;
        end else begin
            rbin_q  <= sync_bin;
            upd_q   <= (delta_d != '0);
            delta_q <= delta_d;
        end
    end

    assign wq_rbin       = rbin_q;
    assign wq_rptr_upd   = upd_q;
    assign wq_rptr_delta = delta_q;

    if (CHK_EN) begin : g_chk
        logic illegal;
        logic err_q;
        logic err_d;

        // Any difference above one FIFO depth is either backward motion or an overrun.
        assign illegal = (delta_d > DEPTH);

        always_comb begin
            err_d = err_q;
            if (illegal) begin
                err_d = 1'b1;
            end else if (gray_err_clr) begin
                err_d = 1'b0;
            end
        end

        always_ff @(posedge wclk) begin
            if (wrst) begin
                err_q <= 1'b0;
            end else begin
                err_q <= err_d;
            end
        end

        assign gray_err = err_q;
    end else begin : g_no_chk
        logic unused_gray_err_clr;
        assign unused_gray_err_clr = gray_err_clr;
        assign gray_err = 1'b0;
    end

endmodule

// File: tb/tb_sync_ptr_gray_nstage.sv
// Directed bench for sync_ptr_gray_nstage with ADDRSIZE=4, SYNC_STAGES=3, CHK_EN=1.
module tb_sync_ptr_gray_nstage;

    localparam int unsigned AW = 4;
    localparam int unsigned SS = 3;

    logic          wclk;
    logic          wrst;
    logic [AW:0]   rptr;
    logic [AW:0]   wq_rptr;
    logic [AW:0]   wq_rbin;
    logic          wq_rptr_upd;
    logic [AW:0]   wq_rptr_delta;
    logic          gray_err;
    logic          gray_err_clr;

    int checks = 0;
    int errors = 0;

    sync_ptr_gray_nstage #(
        .ADDRSIZE    (AW),
        .SYNC_STAGES (SS),
        .CHK_EN      (1'b1)
    ) dut (
        .wclk          (wclk),
        .wrst          (wrst),
        .rptr          (rptr),
        .wq_rptr       (wq_rptr),
        .wq_rbin       (wq_rbin),
        .wq_rptr_upd   (wq_rptr_upd),
        .wq_rptr_delta (wq_rptr_delta),
        .gray_err      (gray_err),
        .gray_err_clr  (gray_err_clr)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [AW:0] g(input int unsigned b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    // Advance one edge, then sample 1 time unit later.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wclk);
            #1;
        end
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        rptr = g(7);
        gray_err_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if ({wq_rptr, wq_rbin, wq_rptr_upd, wq_rptr_delta, gray_err} !== '0) begin
                errors++;
                $display("FAIL reset_outputs_zero cyc%0d: got rptr=%0h rbin=%0d upd=%0b delta=%0d err=%0b expected all 0",
                         i, wq_rptr, wq_rbin, wq_rptr_upd, wq_rptr_delta, gray_err);
            end
        end
        wrst = 1'b0;
        rptr = 5'b00001;
        step(2);
        checks++;
        if (wq_rptr !== 5'd0) begin errors++; $display("FAIL lat_rptr_edge2: got %0h expected 0", wq_rptr); end
        step(1);
        checks++;
        if (wq_rptr !== 5'b00001) begin errors++; $display("FAIL lat_rptr_edge3: got %0h expected 1", wq_rptr); end
        checks++;
        if (wq_rptr_upd !== 1'b0) begin errors++; $display("FAIL lat_upd_edge3: got %0b expected 0", wq_rptr_upd); end
        step(1);
        checks++;
        if (wq_rbin !== 5'd1) begin errors++; $display("FAIL lat_rbin_edge4: got %0d expected 1", wq_rbin); end
        checks++;
        if (wq_rptr_upd !== 1'b1) begin errors++; $display("FAIL lat_upd_edge4: got %0b expected 1", wq_rptr_upd); end
        checks++;
        if (wq_rptr_delta !== 5'd1) begin errors++; $display("FAIL lat_delta_edge4: got %0d expected 1", wq_rptr_delta); end
        step(1);
        checks++;
        if ({wq_rptr_upd, wq_rptr_delta} !== 6'd0) begin
            errors++;
            $display("FAIL lat_pulse_end: got upd=%0b delta=%0d expected 0/0", wq_rptr_upd, wq_rptr_delta);
        end
    endtask

    task automatic test_multi_step();
        rptr = g(2);
        step(5);
        checks++;
        if (wq_rbin !== 5'd2) begin errors++; $display("FAIL ms_pre_rbin: got %0d expected 2", wq_rbin); end
        rptr = g(5);
        step(3);
        checks++;
        if (wq_rptr !== 5'b00111) begin errors++; $display("FAIL ms_rptr: got %0h expected 07", wq_rptr); end
        step(1);
        checks++;
        if (wq_rbin !== 5'd5) begin errors++; $display("FAIL ms_rbin: got %0d expected 5", wq_rbin); end
        checks++;
        if (wq_rptr_upd !== 1'b1) begin errors++; $display("FAIL ms_upd: got %0b expected 1", wq_rptr_upd); end
        checks++;
        if (wq_rptr_delta !== 5'd3) begin errors++; $display("FAIL ms_delta: got %0d expected 3", wq_rptr_delta); end
        checks++;
        if (gray_err !== 1'b0) begin errors++; $display("FAIL ms_err: got %0b expected 0", gray_err); end
        step(1);
        checks++;
        if (wq_rptr_upd !== 1'b0) begin errors++; $display("FAIL ms_single_pulse: got %0b expected 0", wq_rptr_upd); end
    endtask

    task automatic test_wrap();
        rptr = g(16);
        step(5);
        rptr = g(31);
        step(5);
        checks++;
        if (wq_rbin !== 5'd31) begin errors++; $display("FAIL wrap_pre_rbin: got %0d expected 31", wq_rbin); end
        rptr = g(0);
        step(4);
        checks++;
        if (wq_rbin !== 5'd0) begin errors++; $display("FAIL wrap_rbin: got %0d expected 0", wq_rbin); end
        checks++;
        if (wq_rptr_upd !== 1'b1) begin errors++; $display("FAIL wrap_upd: got %0b expected 1", wq_rptr_upd); end
        checks++;
        if (wq_rptr_delta !== 5'd1) begin errors++; $display("FAIL wrap_delta: got %0d expected 1", wq_rptr_delta); end
        checks++;
        if (gray_err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %0b expected 0", gray_err); end
    endtask

    task automatic test_illegal_backward();
        rptr = g(10);
        step(5);
        checks++;
        if (wq_rbin !== 5'd10) begin errors++; $display("FAIL bk_pre_rbin: got %0d expected 10", wq_rbin); end
        rptr = g(8);
        step(3);
        checks++;
        if (gray_err !== 1'b0) begin errors++; $display("FAIL bk_err_early: got %0b expected 0", gray_err); end
        step(1);
        checks++;
        if (wq_rptr_delta !== 5'd30) begin errors++; $display("FAIL bk_delta: got %0d expected 30", wq_rptr_delta); end
        checks++;
        if (wq_rptr_upd !== 1'b1) begin errors++; $display("FAIL bk_upd: got %0b expected 1", wq_rptr_upd); end
        checks++;
        if (gray_err !== 1'b1) begin errors++; $display("FAIL bk_err_set: got %0b expected 1", gray_err); end
        checks++;
        if (wq_rbin !== 5'd8) begin errors++; $display("FAIL bk_rbin: got %0d expected 8", wq_rbin); end
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if (gray_err !== 1'b1) begin
                errors++;
                $display("FAIL bk_err_sticky cyc%0d: got %0b expected 1", i, gray_err);
            end
        end
    endtask

    task automatic test_clear_vs_set();
        rptr = g(4);
        step(3);
        gray_err_clr = 1'b1;
        step(1);
        gray_err_clr = 1'b0;
        checks++;
        if (gray_err !== 1'b1) begin errors++; $display("FAIL cs_set_wins: got %0b expected 1", gray_err); end
        checks++;
        if (wq_rptr_delta !== 5'd28) begin errors++; $display("FAIL cs_delta: got %0d expected 28", wq_rptr_delta); end
        checks++;
        if (wq_rbin !== 5'd4) begin errors++; $display("FAIL cs_rbin: got %0d expected 4", wq_rbin); end
        gray_err_clr = 1'b1;
        step(1);
        gray_err_clr = 1'b0;
        checks++;
        if (gray_err !== 1'b0) begin errors++; $display("FAIL cs_quiet_clear: got %0b expected 0", gray_err); end
        step(1);
        checks++;
        if (gray_err !== 1'b0) begin errors++; $display("FAIL cs_stays_clear: got %0b expected 0", gray_err); end
    endtask

    task automatic test_mid_reset();
        rptr = g(12);
        step(5);
        checks++;
        if (wq_rbin !== 5'd12) begin errors++; $display("FAIL mr_pre_rbin: got %0d expected 12", wq_rbin); end
        wrst = 1'b1;
        step(1);
        wrst = 1'b0;
        checks++;
        if ({wq_rptr, wq_rbin, wq_rptr_upd, wq_rptr_delta, gray_err} !== '0) begin
            errors++;
            $display("FAIL mr_flush: got rptr=%0h rbin=%0d upd=%0b delta=%0d err=%0b expected all 0",
                     wq_rptr, wq_rbin, wq_rptr_upd, wq_rptr_delta, gray_err);
        end
        step(3);
        checks++;
        if (wq_rptr !== 5'b01010) begin errors++; $display("FAIL mr_rptr: got %0h expected 0a", wq_rptr); end
        checks++;
        if (wq_rptr_upd !== 1'b0) begin errors++; $display("FAIL mr_upd_early: got %0b expected 0", wq_rptr_upd); end
        step(1);
        checks++;
        if (wq_rptr_upd !== 1'b1) begin errors++; $display("FAIL mr_upd: got %0b expected 1", wq_rptr_upd); end
        checks++;
        if (wq_rptr_delta !== 5'd12) begin errors++; $display("FAIL mr_delta: got %0d expected 12", wq_rptr_delta); end
        checks++;
        if (wq_rbin !== 5'd12) begin errors++; $display("FAIL mr_rbin: got %0d expected 12", wq_rbin); end
        checks++;
        if (gray_err !== 1'b0) begin errors++; $display("FAIL mr_err: got %0b expected 0", gray_err); end
    endtask

    initial begin
        wrst = 1'b1;
        rptr = '0;
        gray_err_clr = 1'b0;
        test_reset();
        test_multi_step();
        test_wrap();
        test_illegal_backward();
        test_clear_vs_set();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
